// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding constants for the instruction encoder: immSel codes,
// major opcodes, field bit positions and the pipeline occupancy states.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    IMMSEL_R     = 3'b000,
    IMMSEL_I     = 3'b001,
    IMMSEL_B     = 3'b010,
    IMMSEL_S     = 3'b011,
    IMMSEL_LUI   = 3'b100,
    IMMSEL_AUIPC = 3'b101,
    IMMSEL_JAL   = 3'b110,
    IMMSEL_JALR  = 3'b111
  } immSel_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam int unsigned OPCODE_LSB = 32'd0;
  localparam int unsigned RD_LSB     = 32'd7;
  localparam int unsigned FUNCT3_LSB = 32'd12;
  localparam int unsigned RS1_LSB    = 32'd15;
  localparam int unsigned RS2_LSB    = 32'd20;
  localparam int unsigned FUNCT7_LSB = 32'd25;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [2:0]  sel;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// Combinational packer: decoded fields + immediate -> RV32I word. Defining
// IMM_RANGE_CHECK_EN adds the representability check on the immediate.
module inst_encoder_imm_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  // Field placement per instruction format; excess immediate bits drop out.
  always_comb begin
    inst = 32'h0000_0000;
    case (sel)
      IMMSEL_R:     inst = {funct7, rs2, rs1, funct3, rd, opcode};
      IMMSEL_I,
      IMMSEL_JALR:  inst = {imm[11:0], rs1, funct3, rd, opcode};
      IMMSEL_S:     inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IMMSEL_B:     inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      IMMSEL_LUI,
      IMMSEL_AUIPC: inst = {imm[31:12], rd, opcode};
      IMMSEL_JAL:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:      inst = 32'h0000_0000;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // True when imm[31:msb] is not a pure sign extension of bit msb.
  function automatic logic notSignExt(input logic [31:0] value, input logic [4:0] msb);
    logic [31:0] upper;
    upper = 32'($signed(value) >>> msb);
    return !((upper == 32'h0000_0000) || (upper == 32'hFFFF_FFFF));
  endfunction

  // Flag immediates the selected format cannot carry exactly.
  always_comb begin
    err = 1'b0;
    case (sel)
      IMMSEL_R:     err = 1'b0;
      IMMSEL_I,
      IMMSEL_JALR,
      IMMSEL_S:     err = notSignExt(imm, 5'd11);
      IMMSEL_B:     err = notSignExt(imm, 5'd12) || imm[0];
      IMMSEL_JAL:   err = notSignExt(imm, 5'd20) || imm[0];
      IMMSEL_LUI,
      IMMSEL_AUIPC: err = (imm[11:0] != 12'h000);
      default:      err = 1'b0;
    endcase
  end
`else
  logic unusedImmLsb;
  assign unusedImmLsb = imm[0];
  assign err          = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with a streaming byte-address
// counter. Optional immediate range check: define IMM_RANGE_CHECK_EN.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int                DATA_LENGTH = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = {ADDR_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_sel,
  input  logic [6:0]             in_opcode,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [2:0]             in_funct3,
  input  logic [6:0]             in_funct7,
  input  logic [DATA_LENGTH-1:0] in_imm,
  input  logic                   addr_load,
  input  logic [ADDR_W-1:0]      addr_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] out_inst,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_err
);

  occ_e                   occState, occNext;
  fields_t                s1Fields;
  logic                   s1Valid, s2Valid, s2Err, packErr;
  logic [DATA_LENGTH-1:0] s2Inst, packInst;
  logic [ADDR_W-1:0]      addr;
  logic                   accept, drain, s2Load;

  assign in_ready = !rst && ((occState != OCC_FULL) || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = s2Valid && out_ready;
  assign s2Load   = s1Valid && (!s2Valid || out_ready);

  inst_encoder_imm_pack uPack (
    .sel    (s1Fields.sel),
    .opcode (s1Fields.opcode),
    .rd     (s1Fields.rd),
    .rs1    (s1Fields.rs1),
    .rs2    (s1Fields.rs2),
    .funct3 (s1Fields.funct3),
    .funct7 (s1Fields.funct7),
    .imm    (s1Fields.imm),
    .inst   (packInst),
    .err    (packErr)
  );

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) occState <= OCC_EMPTY;
    else     occState <= occNext;
  end

  // Occupancy tracks accepted-minus-drained words across both stages.
  always_comb begin
    occNext = occState;
    case (occState)
      OCC_EMPTY: if (accept)            occNext = OCC_ONE;
                 else                   occNext = OCC_EMPTY;
      OCC_ONE:   if (accept && !drain)  occNext = OCC_FULL;
                 else if (!accept && drain) occNext = OCC_EMPTY;
                 else                   occNext = OCC_ONE;
      OCC_FULL:  if (drain && !accept)  occNext = OCC_ONE;
                 else                   occNext = OCC_FULL;
      default:                          occNext = OCC_EMPTY;
    endcase
  end

  // Stage 1 captures raw fields; it empties only when stage 2 takes its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid  <= 1'b0;
      s1Fields <= '0;
    end else if (accept) begin
      s1Valid  <= 1'b1;
      s1Fields <= '{sel: in_sel, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, funct7: in_funct7, imm: in_imm};
    end else if (s2Load) begin
      s1Valid  <= 1'b0;
    end else begin
      s1Valid  <= s1Valid;
    end
  end

  // Stage 2 holds the encoded word and its error flag until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid <= 1'b0;
      s2Inst  <= {DATA_LENGTH{1'b0}};
      s2Err   <= 1'b0;
    end else if (s2Load) begin
      s2Valid <= 1'b1;
      s2Inst  <= packInst;
      s2Err   <= packErr;
    end else if (out_ready) begin
      s2Valid <= 1'b0;
    end else begin
      s2Valid <= s2Valid;
    end
  end

  // A load beats the increment, so a word handshaked alongside it keeps the old address.
  always_ff @(posedge clk) begin
    if (rst)            addr <= RESET_ADDR;
    else if (addr_load) addr <= addr_val;
    else if (drain)     addr <= addr + ADDR_W'(32'd4);
    else                addr <= addr;
  end

  assign out_valid = s2Valid;
  assign out_inst  = s2Inst;
  assign out_err   = s2Err;
  assign out_addr  = addr;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table through a scoreboard,
// plus latency, backpressure, reset, address wrap and load sequences.
module tb_inst_encoder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, addr_load, out_valid, out_ready, out_err;
  logic [2:0]    in_sel, in_funct3;
  logic [6:0]    in_opcode, in_funct7;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm, out_inst;
  logic [AW-1:0] addr_val, out_addr;

  always #5 clk = ~clk;

  inst_encoder #(.DATA_LENGTH(32), .ADDR_W(AW), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_load(addr_load), .addr_val(addr_val), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        errChk;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  vec_t          vecs[16];
  exp_t          sbq[$];
  exp_t          popE;
  logic [31:0]   curInst;
  logic          curErr;
  logic [AW-1:0] expAddr;
  logic          holdPending;
  logic [31:0]   holdInst;
  logic [AW-1:0] holdAddr;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector (called just after a rising edge) and hold it until accepted.
  task automatic sendVec(input vec_t v);
    int waitCnt;
    waitCnt   = 0;
    in_sel    = v.sel;  in_opcode = v.op;  in_rd  = v.rd;  in_rs1 = v.rs1;
    in_rs2    = v.rs2;  in_funct3 = v.f3;  in_funct7 = v.f7; in_imm = v.imm;
    curInst   = v.inst;
`ifdef IMM_RANGE_CHECK_EN
    curErr    = v.errChk;
`else
    curErr    = 1'b0;
`endif
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL acceptTimeout: in_ready stayed %b, expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  // Scoreboard monitor: pushes on accept, pops/compares on output handshake.
  initial begin
    expAddr     = 8'h00;
    holdPending = 1'b0;
    holdInst    = 32'h0;
    holdAddr    = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        expAddr     = 8'h00;
        holdPending = 1'b0;
      end else begin
        if (holdPending) begin
          check("holdValid", 32'(out_valid), 32'd1);
          check("holdInst", out_inst, holdInst);
          check("holdAddr", 32'(out_addr), 32'(holdAddr));
        end
        holdPending = out_valid && !out_ready;
        holdInst    = out_inst;
        holdAddr    = out_addr;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious: got word %h, expected no word", out_inst);
          end else begin
            popE = sbq.pop_front();
            check("inst", out_inst, popE.inst);
            check("addr", 32'(out_addr), 32'(expAddr));
            check("err", 32'(out_err), 32'(popE.err));
          end
          expAddr = expAddr + 8'd4;
        end
        if (addr_load) expAddr = addr_val;
        if (in_valid && in_ready) sbq.push_back('{curInst, curErr});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL globalTimeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00500093, 1'b0};
    vecs[1]  = '{3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFE208EE3, 1'b0};
    vecs[2]  = '{3'b110, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,          32'h008000EF, 1'b0};
    vecs[3]  = '{3'b000, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'd0,    32'h402081B3, 1'b0};
    vecs[4]  = '{3'b011, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020A423, 1'b0};
    vecs[5]  = '{3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h123452B7, 1'b0};
    vecs[6]  = '{3'b101, 7'b0010111, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 32'hFFFFF517, 1'b0};
    vecs[7]  = '{3'b111, 7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0,          32'h00008067, 1'b0};
    vecs[8]  = '{3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h80000093, 1'b1};
    vecs[9]  = '{3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6,          32'h00208363, 1'b0};
    vecs[10] = '{3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          32'h00208163, 1'b1};
    vecs[11] = '{3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,          32'h000002B7, 1'b1};
    vecs[12] = '{3'b110, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8,  32'hFF9FF06F, 1'b0};
    vecs[13] = '{3'b110, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000,  32'h800000EF, 1'b1};
    vecs[14] = '{3'b011, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_F7FF,  32'h7E20AFA3, 1'b1};
    vecs[15] = '{3'b111, 7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,  32'hFFF08067, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_val = 8'h00;
    in_sel = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0; curInst = 32'd0; curErr = 1'b0;

    // Reset state.
    tick(); tick();
    @(negedge clk);
    check("rstOutValid", 32'(out_valid), 32'd0);
    check("rstOutInst", out_inst, 32'h0);
    check("rstOutErr", 32'(out_err), 32'd0);
    check("rstOutAddr", 32'(out_addr), 32'd0);
    check("rstInReady", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Two-cycle latency of the first word.
    sendVec(vecs[0]);
    @(negedge clk);
    check("lat1Valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat2Valid", 32'(out_valid), 32'd1);
    check("lat2Inst", out_inst, 32'h00500093);
    check("lat2Addr", 32'(out_addr), 32'd0);
    tick();

    // Whole table, back to back.
    for (int i = 1; i < 16; i++) sendVec(vecs[i]);
    waitDrain();

    // Reset with the pipeline full and stalled.
    out_ready = 1'b0;
    sendVec(vecs[0]);
    sendVec(vecs[2]);
    @(negedge clk);
    check("fullValid", 32'(out_valid), 32'd1);
    check("fullInReady", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstFullValid", 32'(out_valid), 32'd0);
    check("rstFullAddr", 32'(out_addr), 32'd0);
    check("rstFullInst", out_inst, 32'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    begin
      logic stale;
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (out_valid) stale = 1'b1;
      end
      check("noStaleWord", 32'(stale), 32'd0);
    end
    tick();

    // Backpressure: five words, consumer stalls for three cycles.
    fork
      begin
        for (int i = 0; i < 5; i++) sendVec(vecs[i + 1]);
      end
      begin
        tick(); tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("bpInReady", 32'(in_ready), 32'd0);
        tick(); tick(); tick();
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Load near the top of the 8-bit space and wrap through zero.
    addr_load = 1'b1;
    addr_val  = 8'hFC;
    tick();
    addr_load = 1'b0;
    @(negedge clk);
    check("loadAddr", 32'(out_addr), 32'h0000_00FC);
    tick();
    sendVec(vecs[0]);
    sendVec(vecs[2]);
    waitDrain();
    check("wrapAddr", 32'(out_addr), 32'h0000_0004);

    // Load coinciding with a handshake: that word keeps its old address.
    out_ready = 1'b0;
    sendVec(vecs[1]);
    sendVec(vecs[3]);
    addr_load = 1'b1;
    addr_val  = 8'h80;
    out_ready = 1'b1;
    tick();
    addr_load = 1'b0;
    @(negedge clk);
    check("loadWinsAddr", 32'(out_addr), 32'h0000_0080);
    check("loadWinsValid", 32'(out_valid), 32'd1);
    tick();
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
